// File: rtl/voice_allocator_if.sv
// ----------------------------------------------------------------------------
// voice_allocator_if
// Event bus between the command decoder and the voice allocator.
//   ev_valid   : event present (decoder -> allocator)
//   ev_ready   : allocator can accept an event (allocator -> decoder)
//   ev_note_on : 1 = note-on, 0 = note-off
//   ev_key     : key (note number)
//   ev_freq    : frequency word for a note-on
//   panic      : synchronous all-notes-off
// master = decoder side, slave = allocator side.
// ----------------------------------------------------------------------------
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif

interface voice_allocator_if #(
    parameter int unsigned N_VOICES = `N_OSCILLATORS,
    parameter int unsigned FREQ_W   = 32,
    parameter int unsigned KEY_W    = 7
);
    logic              ev_valid;
    logic              ev_ready;
    logic              ev_note_on;
    logic [KEY_W-1:0]  ev_key;
    logic [FREQ_W-1:0] ev_freq;
    logic              panic;

    modport master (
        output ev_valid, ev_note_on, ev_key, ev_freq, panic,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_note_on, ev_key, ev_freq, panic,
        output ev_ready
    );
endinterface

// File: rtl/voice_allocator.sv
// ----------------------------------------------------------------------------
// voice_allocator
// Assigns note-on/note-off events to a bank of oscillators. A note-on
// retriggers the voice already holding the key, else takes the lowest free
// voice, else steals the oldest voice. Fixed 4-cycle event processing.
//   clk, rstn     : clock, asynchronous active-low reset
//   ev            : event bus (slave modport)
//   voice_enable  : per-oscillator enable
//   voice_reset   : per-oscillator envelope reset (one-cycle pulse)
//   voice_freq    : per-oscillator frequency word
//   num_enabled   : registered popcount of voice_enable
//   steal         : one-cycle pulse when an active voice is stolen
// ----------------------------------------------------------------------------
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif

module voice_allocator #(
    parameter int unsigned N_VOICES = `N_OSCILLATORS,
    parameter int unsigned FREQ_W   = 32,
    parameter int unsigned KEY_W    = 7,
    parameter int unsigned AGE_W    = 8
) (
    input  logic                             clk,
    input  logic                             rstn,
    voice_allocator_if.slave                 ev,
    output logic [N_VOICES-1:0]              voice_enable,
    output logic [N_VOICES-1:0]              voice_reset,
    output logic [N_VOICES-1:0][FREQ_W-1:0]  voice_freq,
    output logic [31:0]                      num_enabled,
    output logic                             steal
);
    localparam int unsigned IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY, CLEAR} state_t;

    state_t                          r_state;
    logic                            r_up;
    logic                            r_note_on;
    logic [KEY_W-1:0]                r_key;
    logic [FREQ_W-1:0]               r_freq;
    logic [KEY_W-1:0]                r_keys [N_VOICES];
    logic [AGE_W-1:0]                r_ages [N_VOICES];
    logic [N_VOICES-1:0]             r_enable;
    logic [N_VOICES-1:0]             r_reset;
    logic [N_VOICES-1:0][FREQ_W-1:0] r_freq_out;
    logic [31:0]                     r_num;
    logic                            r_steal;
    logic                            r_match_ok;
    logic                            r_free_ok;
    logic [IDX_W-1:0]                r_match_idx;
    logic [IDX_W-1:0]                r_free_idx;
    logic [IDX_W-1:0]                r_old_idx;

    logic                            w_match_ok;
    logic                            w_free_ok;
    logic                            w_old_seen;
    logic [IDX_W-1:0]                w_match_idx;
    logic [IDX_W-1:0]                w_free_idx;
    logic [IDX_W-1:0]                w_old_idx;
    logic [AGE_W-1:0]                w_old_age;
    logic [IDX_W-1:0]                w_tgt;
    logic [31:0]                     w_count;

    // ready is held low until the first edge after reset release, and
    // whenever panic is asserted so a concurrent event is never accepted.
    assign ev.ev_ready   = r_up & (r_state == IDLE) & ~ev.panic;
    assign voice_enable  = r_enable;
    assign voice_reset   = r_reset;
    assign voice_freq    = r_freq_out;
    assign num_enabled   = r_num;
    assign steal         = r_steal;

    // Voice searches; ascending scans keep the lowest index on ties.
    always_comb begin
        w_match_ok  = 1'b0;
        w_match_idx = '0;
        w_free_ok   = 1'b0;
        w_free_idx  = '0;
        w_old_seen  = 1'b0;
        w_old_idx   = '0;
        w_old_age   = '0;
        w_count     = '0;
        for (int unsigned i = 0; i < N_VOICES; i++) begin
            if (!w_match_ok && r_enable[i] && (r_keys[i] == r_key)) begin
                w_match_ok  = 1'b1;
                w_match_idx = IDX_W'(i);
            end
            if (!w_free_ok && !r_enable[i]) begin
                w_free_ok  = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_enable[i] && (!w_old_seen || (r_ages[i] > w_old_age))) begin
                w_old_seen = 1'b1;
                w_old_idx  = IDX_W'(i);
                w_old_age  = r_ages[i];
            end
            w_count = w_count + 32'(r_enable[i]);
        end
    end

    always_comb begin
        if (r_match_ok)
            w_tgt = r_match_idx;
        else if (r_free_ok)
            w_tgt = r_free_idx;
        else
            w_tgt = r_old_idx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_up        <= 1'b0;
            r_note_on   <= 1'b0;
            r_key       <= '0;
            r_freq      <= '0;
            r_enable    <= '0;
            r_reset     <= '0;
            r_freq_out  <= '0;
            r_num       <= '0;
            r_steal     <= 1'b0;
            r_match_ok  <= 1'b0;
            r_free_ok   <= 1'b0;
            r_match_idx <= '0;
            r_free_idx  <= '0;
            r_old_idx   <= '0;
            for (int unsigned i = 0; i < N_VOICES; i++) begin
                r_keys[i] <= '0;
                r_ages[i] <= '0;
            end
        end else begin
            r_up    <= 1'b1;
            r_steal <= 1'b0;
            r_num   <= w_count;
            if (ev.panic) begin
                r_state  <= IDLE;
                r_enable <= '0;
                r_reset  <= '0;
                for (int unsigned i = 0; i < N_VOICES; i++) begin
                    r_keys[i] <= '0;
                    r_ages[i] <= '0;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (ev.ev_valid && ev.ev_ready) begin
                            r_note_on <= ev.ev_note_on;
                            r_key     <= ev.ev_key;
                            r_freq    <= ev.ev_freq;
                            r_state   <= LOOKUP;
                        end
                    end
                    LOOKUP: begin
                        r_match_ok  <= w_match_ok;
                        r_match_idx <= w_match_idx;
                        r_free_ok   <= w_free_ok;
                        r_free_idx  <= w_free_idx;
                        r_old_idx   <= w_old_idx;
                        r_state     <= APPLY;
                    end
                    APPLY: begin
                        if (r_note_on) begin
                            for (int unsigned i = 0; i < N_VOICES; i++) begin
                                if (IDX_W'(i) == w_tgt)
                                    r_ages[i] <= '0;
                                else if (r_enable[i] && (r_ages[i] != '1))
                                    r_ages[i] <= r_ages[i] + AGE_W'(1);
                            end
                            r_reset[w_tgt]    <= 1'b1;
                            r_freq_out[w_tgt] <= r_freq;
                            if (!r_match_ok) begin
                                r_keys[w_tgt]   <= r_key;
                                r_enable[w_tgt] <= 1'b1;
                                r_steal         <= ~r_free_ok;
                            end
                        end else if (r_match_ok) begin
                            r_enable[r_match_idx] <= 1'b0;
                        end
                        r_state <= CLEAR;
                    end
                    CLEAR: begin
                        r_reset <= '0;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
